// File: rtl/bcd_seq_converter.sv
// Iterative shift-and-add-3 (double-dabble) binary-to-BCD converter, one bit per clock.
// Optional LEADING_ZERO_BLANK_EN adds a registered per-digit leading-zero blank output.
module bcd_seq_converter #(
    parameter int WIDTH  = 13,
    parameter int DIGITS = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
`ifdef LEADING_ZERO_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [WIDTH-1:0]      r_shreg, w_shreg_nxt;
    logic [4*DIGITS-1:0]   r_scratch, w_scratch_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic                  r_carry, w_carry_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;
    logic [4*DIGITS-1:0]   r_bcd, w_bcd_nxt;
    logic                  r_ovf, w_ovf_nxt;

    logic [4*DIGITS-1:0]       w_adj;
    logic [4*DIGITS+WIDTH:0]   w_cat;
    logic [4*DIGITS-1:0]       w_scr_shift;
    logic [WIDTH-1:0]          w_sh_shift;
    logic                      w_out;

    // Adjust every digit first, then shift the whole {scratch, shreg} chain by one.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
        end
        w_cat       = {w_adj, r_shreg, 1'b0};
        w_out       = w_cat[4*DIGITS+WIDTH];
        w_scr_shift = w_cat[4*DIGITS+WIDTH-1 -: 4*DIGITS];
        w_sh_shift  = w_cat[WIDTH-1:0];
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_scratch_nxt = r_scratch;
        w_cnt_nxt     = r_cnt;
        w_carry_nxt   = r_carry;
        w_done_nxt    = 1'b0;
        w_bcd_nxt     = r_bcd;
        w_ovf_nxt     = r_ovf;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_shreg_nxt   = bin;
                    w_scratch_nxt = '0;
                    w_carry_nxt   = 1'b0;
                    w_cnt_nxt     = CNT_W'(WIDTH);
                    w_state_nxt   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_shreg_nxt   = w_sh_shift;
                w_scratch_nxt = w_scr_shift;
                w_carry_nxt   = r_carry | w_out;
                w_cnt_nxt     = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                    w_bcd_nxt   = w_scr_shift;
                    w_ovf_nxt   = r_carry | w_out;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt == S_SHIFT);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_carry   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_scratch <= w_scratch_nxt;
            r_cnt     <= w_cnt_nxt;
            r_carry   <= w_carry_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_bcd     <= w_bcd_nxt;
            r_ovf     <= w_ovf_nxt;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign overflow = r_ovf;

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] r_blank, w_blank_nxt;
    logic              w_zero_above;

    // Digit 0 is never blanked so a zero value still shows one "0".
    always_comb begin
        w_blank_nxt  = '0;
        w_zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zero_above   = w_zero_above & (w_scr_shift[4*i +: 4] == 4'd0);
            w_blank_nxt[i] = w_zero_above;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_blank <= '0;
        else if (r_state == S_SHIFT && r_cnt == CNT_W'(1))
            r_blank <= w_blank_nxt;
    end

    assign blank = r_blank;
`endif

endmodule
